// File: rtl/light_dance_pkg.sv
// Shared constants for the light-dance pattern register: motion mode codes and default sizes.
package light_dance_pkg;

  localparam int MODE_W    = 3;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD   = 3'd0,
    MODE_SHL    = 3'd1,
    MODE_SHR    = 3'd2,
    MODE_ROL    = 3'd3,
    MODE_ROR    = 3'd4,
    MODE_BOUNCE = 3'd5,
    MODE_INV    = 3'd6,
    MODE_RSVD   = 3'd7
  } mode_e;

endpackage

// File: rtl/light_dance_prescaler.sv
// Step prescaler: fires tick every div+1 enabled cycles; clr restarts the count.
import light_dance_pkg::*;

module light_dance_prescaler #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // >= rather than == so that shrinking div mid-count fires on the next enabled edge
  assign tick = en & ~clr & (cnt >= div);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt >= div) cnt <= '0;
      else            cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_dance_reg.sv
// Lamp pattern register with parallel load, prescaled stepping and motion modes.
// Define LIGHT_DANCE_BOUNCE_EN to build the BOUNCE mode and its direction register.
import light_dance_pkg::*;

module light_dance_reg #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic [MODE_W-1:0] mode,
  input  logic [DIV_W-1:0]  div,
  input  logic              en,
  input  logic              sin,
  output logic [WIDTH-1:0]  dout,
  output logic              step,
  output logic              dir
);

  logic             tick;
  logic [WIDTH-1:0] nxt;
`ifdef LIGHT_DANCE_BOUNCE_EN
  logic             dir_nxt;
`endif

  light_dance_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .arst (arst),
    .en   (en),
    .clr  (load),
    .div  (div),
    .tick (tick)
  );

  always_comb begin
    nxt = dout;
`ifdef LIGHT_DANCE_BOUNCE_EN
    dir_nxt = dir;
`endif
    case (mode_e'(mode))
      MODE_SHL: nxt = {dout[WIDTH-2:0], sin};
      MODE_SHR: nxt = {sin, dout[WIDTH-1:1]};
      MODE_ROL: nxt = {dout[WIDTH-2:0], dout[WIDTH-1]};
      MODE_ROR: nxt = {dout[0], dout[WIDTH-1:1]};
      MODE_INV: nxt = ~dout;
`ifdef LIGHT_DANCE_BOUNCE_EN
      // Direction flips on the same edge the lit lamp reaches an end
      MODE_BOUNCE: begin
        if (!dir) begin
          nxt = {dout[WIDTH-2:0], 1'b0};
          if (nxt[WIDTH-1]) dir_nxt = 1'b1;
        end else begin
          nxt = {1'b0, dout[WIDTH-1:1]};
          if (nxt[0]) dir_nxt = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      dout <= '0;
      step <= 1'b0;
    end else if (load) begin
      dout <= din;
      step <= 1'b0;
    end else if (tick) begin
      dout <= nxt;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end

`ifdef LIGHT_DANCE_BOUNCE_EN
  always_ff @(posedge clk or negedge arst) begin
    if (!arst)     dir <= 1'b0;
    else if (load) dir <= 1'b0;
    else if (tick) dir <= dir_nxt;
  end
`else
  assign dir = 1'b0;
`endif

endmodule
